// File: rtl/mux_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux_arb_pkg
// Shared types and constants for the two-source mux select arbiter.
//   arb_state_e : arbiter FSM states (IDLE, GNT_A, GNT_B)
//   SEL_A/SEL_B : encodings of the downstream 2:1 mux select line
//   sel_of()    : mux select value that corresponds to a grant state
// -----------------------------------------------------------------------------
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } arb_state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Only meaningful for grant states; IDLE callers hold the previous select.
    function automatic logic sel_of(input arb_state_e s);
        return (s == GNT_B) ? SEL_B : SEL_A;
    endfunction

endpackage : mux_arb_pkg

// File: rtl/mux_arb_burst_cnt.sv
// -----------------------------------------------------------------------------
// mux_arb_burst_cnt
// Beat counter for one grant tenure. Clear has priority over increment so a
// releasing beat returns the count to zero instead of advancing it.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   i_clr      : return the count to zero (end of tenure)
//   i_inc      : one beat accepted
//   o_cnt      : beats accepted so far in the current tenure
//   o_tc       : terminal count, high when o_cnt == BURST_MAX-1
// -----------------------------------------------------------------------------
module mux_arb_burst_cnt #(
    parameter  int unsigned BURST_MAX = 4,
    localparam int unsigned CNT_W     = $clog2(BURST_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(BURST_MAX - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == TC_VAL);

endmodule : mux_arb_burst_cnt

// File: rtl/mux_select_arbiter.sv
// -----------------------------------------------------------------------------
// mux_select_arbiter
// Two-source round-robin arbiter producing the select line for a downstream
// 2:1 mux (0 -> source A, 1 -> source B). A grant is held for a whole
// transfer (until last) or for at most BURST_MAX beats, then handed to the
// other source if it is requesting, with no idle cycle in between.
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req_a/b    : source A/B has a beat available
//   last       : current beat of the granted source ends its transfer
//   out_ready  : downstream accepts a beat this cycle
//   mux_select : registered mux select, holds last granted value while idle
//   sel_valid  : granted source is presenting a beat (combinational)
//   grant_a/b  : registered one-hot grants
//   burst_cnt  : registered beats accepted in the current tenure
//
// Build option: define ARB_ASSERT_EN to compile protocol/X assertions;
// the design behaves identically with it undefined.
// -----------------------------------------------------------------------------
module mux_select_arbiter
    import mux_arb_pkg::*;
#(
    parameter  int unsigned BURST_MAX = 4,
    localparam int unsigned CNT_W     = $clog2(BURST_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic             req_b,
    input  logic             last,
    input  logic             out_ready,
    output logic             mux_select,
    output logic             sel_valid,
    output logic             grant_a,
    output logic             grant_b,
    output logic [CNT_W-1:0] burst_cnt
);

    arb_state_e r_state;
    arb_state_e w_next_state;
    logic       r_rr_prefer_b;
    logic       w_next_rr_prefer_b;
    logic       r_mux_select;
    logic       w_next_mux_select;
    logic       r_grant_a;
    logic       r_grant_b;
    logic       w_sel_valid;
    logic       w_beat;
    logic       w_release;
    logic       w_tc;

    // Beat / release qualification
    always_comb begin
        w_sel_valid = 1'b0;
        case (r_state)
            GNT_A:   w_sel_valid = req_a;
            GNT_B:   w_sel_valid = req_b;
            default: w_sel_valid = 1'b0;
        endcase
        w_beat    = w_sel_valid & out_ready;
        w_release = w_beat & (last | w_tc);
    end

    // Next-state: on release the other source wins if it is requesting,
    // otherwise the same source starts a fresh tenure, otherwise idle.
    always_comb begin
        w_next_state       = r_state;
        w_next_rr_prefer_b = r_rr_prefer_b;
        case (r_state)
            IDLE: begin
                if (req_a && req_b) begin
                    w_next_state = r_rr_prefer_b ? GNT_B : GNT_A;
                end else if (req_a) begin
                    w_next_state = GNT_A;
                end else if (req_b) begin
                    w_next_state = GNT_B;
                end
            end
            GNT_A: begin
                if (w_release) begin
                    w_next_rr_prefer_b = 1'b1;
                    if (req_b) begin
                        w_next_state = GNT_B;
                    end else if (req_a) begin
                        w_next_state = GNT_A;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            GNT_B: begin
                if (w_release) begin
                    w_next_rr_prefer_b = 1'b0;
                    if (req_a) begin
                        w_next_state = GNT_A;
                    end else if (req_b) begin
                        w_next_state = GNT_B;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        // Select only moves together with a new grant; idle keeps the old one.
        w_next_mux_select = (w_next_state == IDLE) ? r_mux_select
                                                   : sel_of(w_next_state);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_rr_prefer_b <= 1'b0;
            r_mux_select  <= SEL_A;
            r_grant_a     <= 1'b0;
            r_grant_b     <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_rr_prefer_b <= w_next_rr_prefer_b;
            r_mux_select  <= w_next_mux_select;
            r_grant_a     <= (w_next_state == GNT_A);
            r_grant_b     <= (w_next_state == GNT_B);
        end
    end

    mux_arb_burst_cnt #(
        .BURST_MAX (BURST_MAX)
    ) u_burst_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_release),
        .i_inc (w_beat),
        .o_cnt (burst_cnt),
        .o_tc  (w_tc)
    );

    assign mux_select = r_mux_select;
    assign sel_valid  = w_sel_valid;
    assign grant_a    = r_grant_a;
    assign grant_b    = r_grant_b;

`ifdef ARB_ASSERT_EN
    a_outputs_known: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({mux_select, grant_a, grant_b}))
        else $error("%m : mux_select/grant outputs unknown");

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        !(grant_a && grant_b))
        else $error("%m : grant_a and grant_b both asserted");

    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        (32'(burst_cnt) < BURST_MAX))
        else $error("%m : burst_cnt reached BURST_MAX");

    a_inputs_known: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({req_a, req_b, last, out_ready}))
        else $error("%m : unknown value on req_a/req_b/last/out_ready");
`endif

endmodule : mux_select_arbiter
